// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters and mispredict/redirect logic.
// Optional resolved-update and mispredict statistics are built when BTB_STATS_EN is defined.
module btb_predictor #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int PC_W    = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [PC_W-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_en,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_is_jump,
    input  logic            upd_pred_taken,
    input  logic [PC_W-1:0] upd_pred_target,
    input  logic            flush_all,
    output logic            mispredict,
    output logic [PC_W-1:0] correct_pc,
    output logic [31:0]     stat_updates,
    output logic [31:0]     stat_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q    [ENTRIES];

    logic [IDX_W-1:0] fetch_idx, upd_idx;
    logic [TAG_W-1:0] fetch_tag, upd_tag;
    logic             fetch_hit, upd_hit;
    logic [1:0]       unused_fetch_lsb;

    assign fetch_idx        = fetch_pc[IDX_W+1:2];
    assign fetch_tag        = fetch_pc[PC_W-1:IDX_W+2];
    assign upd_idx          = upd_pc[IDX_W+1:2];
    assign upd_tag          = upd_pc[PC_W-1:IDX_W+2];
    assign unused_fetch_lsb = fetch_pc[1:0];

    // Lookup reads pre-edge contents; a same-cycle update is not bypassed.
    assign fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign pred_taken  = fetch_hit && cnt_q[fetch_idx][CNT_W-1];
    assign pred_target = pred_taken ? target_q[fetch_idx] : '0;

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    assign mispredict = upd_en && ((upd_taken != upd_pred_taken) ||
                                   (upd_taken && (upd_target != upd_pred_target)));
    assign correct_pc = upd_taken ? upd_target : upd_pc + PC_W'(4);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else if (flush_all) begin
            // Counters survive a flush; only the valid bits are dropped.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                if (upd_is_jump) begin
                    cnt_q[upd_idx]    <= CNT_MAX;
                    target_q[upd_idx] <= upd_target;
                end else if (upd_taken) begin
                    if (cnt_q[upd_idx] != CNT_MAX) cnt_q[upd_idx] <= cnt_q[upd_idx] + CNT_W'(1);
                    target_q[upd_idx] <= upd_target;
                end else if (cnt_q[upd_idx] != '0) begin
                    cnt_q[upd_idx] <= cnt_q[upd_idx] - CNT_W'(1);
                end
            end else if (upd_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                cnt_q[upd_idx]    <= upd_is_jump ? CNT_MAX : CNT_WEAK;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] upd_cnt_q, mis_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            upd_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (upd_en && (upd_cnt_q != 32'hFFFF_FFFF)) upd_cnt_q <= upd_cnt_q + 32'd1;
            if (mispredict && (mis_cnt_q != 32'hFFFF_FFFF)) mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end

    assign stat_updates     = upd_cnt_q;
    assign stat_mispredicts = mis_cnt_q;
`else
    assign stat_updates     = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: allocation, counter saturation, aliasing, jumps, flush and redirect PC.
module tb_btb_predictor;
    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_is_jump;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        flush_all;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;

    int n_compared   = 0;
    int n_mismatched = 0;
    int exp_updates  = 0;
    int exp_mispred  = 0;

    btb_predictor #(.ENTRIES(16), .CNT_W(2), .PC_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .fetch_pc(fetch_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_is_jump(upd_is_jump), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .flush_all(flush_all),
        .mispredict(mispredict), .correct_pc(correct_pc),
        .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_is_jump = 1'b0; upd_pred_taken = 1'b0; upd_pred_target = '0; flush_all = 1'b0;
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] pc,
                               input logic exp_taken, input logic [31:0] exp_target);
        fetch_pc = pc;
        #1;
        check_eq({tag, "_taken"}, 32'(pred_taken), 32'(exp_taken));
        check_eq({tag, "_target"}, pred_target, exp_target);
    endtask

    // Applies one resolved update for a single cycle, checking redirect outputs before the edge.
    task automatic do_update(input string tag, input logic [31:0] pc, input logic taken,
                             input logic [31:0] target, input logic is_jump,
                             input logic p_taken, input logic [31:0] p_target,
                             input logic exp_mis, input logic [31:0] exp_cpc, input logic flush);
        @(negedge CLK);
        upd_en = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = target;
        upd_is_jump = is_jump; upd_pred_taken = p_taken; upd_pred_target = p_target;
        flush_all = flush;
        #1;
        check_eq({tag, "_mis"}, 32'(mispredict), 32'(exp_mis));
        check_eq({tag, "_cpc"}, correct_pc, exp_cpc);
        exp_updates++;
        if (exp_mis) exp_mispred++;
        @(posedge CLK);
        #1;
        idle_inputs();
    endtask

    task automatic check_stats(input string tag);
`ifdef BTB_STATS_EN
        check_eq({tag, "_upd"}, stat_updates, 32'(exp_updates));
        check_eq({tag, "_mis"}, stat_mispredicts, 32'(exp_mispred));
`else
        check_eq({tag, "_upd"}, stat_updates, 32'h0);
        check_eq({tag, "_mis"}, stat_mispredicts, 32'h0);
`endif
    endtask

    initial begin
        idle_inputs();
        fetch_pc = '0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Reset state
        check_fetch("rst_f40", 32'h40, 1'b0, 32'h0);
        check_eq("rst_mis", 32'(mispredict), 32'h0);
        check_stats("rst_stat");

        // Allocation on taken miss
        do_update("alloc40", 32'h40, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        check_fetch("f40_a", 32'h40, 1'b1, 32'h100);
        check_fetch("f42_a", 32'h42, 1'b1, 32'h100);

        // Counter decrements and holds at zero
        do_update("nt1", 32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h44, 1'b0);
        check_fetch("f40_nt1", 32'h40, 1'b0, 32'h0);
        do_update("nt2", 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44, 1'b0);
        do_update("nt3", 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44, 1'b0);
        do_update("t_from0", 32'h40, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        check_fetch("f40_c1", 32'h40, 1'b0, 32'h0);
        do_update("t_new_tgt", 32'h40, 1'b1, 32'h120, 1'b0, 1'b0, 32'h0, 1'b1, 32'h120, 1'b0);
        check_fetch("f40_c2", 32'h40, 1'b1, 32'h120);

        // Aliasing into index 0
        do_update("alias80", 32'h80, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
        check_fetch("f80", 32'h80, 1'b1, 32'h200);
        check_fetch("f40_gone", 32'h40, 1'b0, 32'h0);
        do_update("ntC0", 32'hC0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hC4, 1'b0);
        check_fetch("f80_keep", 32'h80, 1'b1, 32'h200);
        check_fetch("fC0_miss", 32'hC0, 1'b0, 32'h0);

        // Jumps and target mismatch
        do_update("jmp10", 32'h10, 1'b1, 32'h3C, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3C, 1'b0);
        do_update("nt10", 32'h10, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3C, 1'b1, 32'h14, 1'b0);
        check_fetch("f10_cnt2", 32'h10, 1'b1, 32'h3C);
        do_update("match10", 32'h10, 1'b1, 32'h3C, 1'b0, 1'b1, 32'h3C, 1'b0, 32'h3C, 1'b0);
        do_update("tgt10", 32'h10, 1'b1, 32'h40, 1'b0, 1'b1, 32'h3C, 1'b1, 32'h40, 1'b0);
        check_fetch("f10_tgt", 32'h10, 1'b1, 32'h40);

        // PC wrap on not-taken redirect
        do_update("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 1'b1, 32'h0, 1'b0);
        check_fetch("fFFC_miss", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // No redirect while upd_en is low
        upd_taken = 1'b1; upd_pred_taken = 1'b0; upd_target = 32'h500;
        #1 check_eq("noen_mis", 32'(mispredict), 32'h0);
        idle_inputs();
        check_stats("pre_flush");

        // Flush drops the same-cycle allocation
        do_update("flush", 32'h300, 1'b1, 32'h400, 1'b0, 1'b1, 32'h400, 1'b0, 32'h400, 1'b1);
        check_fetch("f80_fl", 32'h80, 1'b0, 32'h0);
        check_fetch("f10_fl", 32'h10, 1'b0, 32'h0);
        check_fetch("f300_fl", 32'h300, 1'b0, 32'h0);
        check_stats("post_flush");

        // Reset wins over a simultaneous update
        @(negedge CLK);
        RST = 1'b1; upd_en = 1'b1; upd_pc = 32'h20; upd_taken = 1'b1; upd_target = 32'h600;
        @(posedge CLK);
        #1 RST = 1'b0;
        idle_inputs();
        exp_updates = 0;
        exp_mispred = 0;
        check_fetch("f20_rst", 32'h20, 1'b0, 32'h0);
        check_stats("rst2_stat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish before 20000");
        $fatal(1);
    end
endmodule
